// File: rtl/mem_word_arbiter_pkg.sv
// Shared types and constants for the two-port byte-serial word arbiter.
package mem_arb_pkg;

  localparam int BEATS  = 4;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Big-endian byte lane: lane 0 is the most significant byte of the word.
  function automatic logic [BYTE_W-1:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    get_byte = w[31:24];
      2'd1:    get_byte = w[23:16];
      2'd2:    get_byte = w[15:8];
      default: get_byte = w[7:0];
    endcase
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [BYTE_W-1:0] b);
    put_byte = w;
    case (idx)
      2'd0:    put_byte[31:24] = b;
      2'd1:    put_byte[23:16] = b;
      2'd2:    put_byte[15:8]  = b;
      default: put_byte[7:0]   = b;
    endcase
  endfunction

endpackage

// File: rtl/mem_word_arbiter_if.sv
// Fetch port, data port and shared byte-RAM port of the word arbiter.
interface mem_word_arbiter_if #(parameter int ADDR_W = 16);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic [31:0]       f_rdata;
  logic              f_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // arbiter side
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output f_rdata, f_ack, d_rdata, d_ack, mem_addr, mem_we, mem_wdata
  );

  // requesters + RAM side
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  f_rdata, f_ack, d_rdata, d_ack, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_word_arbiter_rr_arbiter2.sv
// Two-way round-robin: bit 0 = fetch, bit 1 = data. After reset fetch wins a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic favour_d;

  // one-hot grant; the favoured port wins when both request
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !favour_d)) gnt = 2'b01;
    else if (req[1])                      gnt = 2'b10;
  end

  // after any grant, favour the port that was not just served
  always_ff @(posedge clk) begin
    if (!rst)                       favour_d <= 1'b0;
    else if (advance && (|gnt))     favour_d <= gnt[0];
  end

endmodule

// File: rtl/mem_word_arbiter.sv
// Serialises 32-bit word requests from a fetch and a data port onto a byte-wide
// synchronous RAM, four beats per word, big-endian.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a request; grant latches port, addr, we, wdata
// BEAT    | one RAM byte per cycle at base+beat; read bytes land a cycle late
// ACK     | last read byte arrives; one-cycle ack to the granted port
module mem_word_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_word_arbiter_if.slave   bus,
  output logic                busy
);

  state_t            state_q, state_d;
  logic [1:0]        beat_q;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       wdata_q;
  logic [31:0]       buf_q;
  logic [31:0]       f_rdata_q, d_rdata_q;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              advance;
  logic [31:0]       word_fin;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic              f_ack, d_ack;
  logic [31:0]       f_rdata, d_rdata;

  assign req     = {bus.d_req, bus.f_req};
  assign advance = (state_q == ST_IDLE) && (|req);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .gnt     (gnt)
  );

  // next state and all port outputs; the final read byte is bypassed straight
  // from the RAM so rdata is valid in the ack cycle itself
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    f_ack     = 1'b0;
    d_ack     = 1'b0;
    word_fin  = {buf_q[31:8], bus.mem_rdata};
    f_rdata   = f_rdata_q;
    d_rdata   = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (|req) state_d = ST_BEAT;
      end
      ST_BEAT: begin
        mem_addr = base_q + ADDR_W'(beat_q);
        if (we_q) begin
          mem_we    = 1'b1;
          mem_wdata = get_byte(wdata_q, beat_q);
        end
        if (beat_q == 2'(BEATS - 1)) state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        if (port_q == PORT_F) begin
          f_ack   = 1'b1;
          f_rdata = word_fin;
        end else begin
          d_ack = 1'b1;
          if (!we_q) d_rdata = word_fin;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state register plus latched transaction and read assembly
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      port_q    <= PORT_F;
      we_q      <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      buf_q     <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            port_q  <= gnt[1];
            we_q    <= gnt[1] & bus.d_we;
            base_q  <= gnt[1] ? bus.d_addr : bus.f_addr;
            wdata_q <= bus.d_wdata;
            beat_q  <= '0;
          end
        end
        ST_BEAT: begin
          beat_q <= beat_q + 2'd1;
          if (!we_q && (beat_q != 2'd0))
            buf_q <= put_byte(buf_q, beat_q - 2'd1, bus.mem_rdata);
        end
        ST_ACK: begin
          if (port_q == PORT_F)  f_rdata_q <= word_fin;
          else if (!we_q)        d_rdata_q <= word_fin;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr;
  assign bus.mem_we    = mem_we;
  assign bus.mem_wdata = mem_wdata;
  assign bus.f_ack     = f_ack;
  assign bus.d_ack     = d_ack;
  assign bus.f_rdata   = f_rdata;
  assign bus.d_rdata   = d_rdata;

endmodule

// File: tb/tb_mem_word_arbiter.sv
// Directed bench for mem_word_arbiter with a behavioural byte RAM.
module tb_mem_word_arbiter;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] ram [0:65535];

  mem_word_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  mem_word_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // synchronous RAM: write at the edge, read data one cycle after the address
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  task automatic wait_ack(input bit is_d, output int cyc);
    cyc = -1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if ((is_d ? bus.d_ack : bus.f_ack) === 1'b1) begin
        cyc = k;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (bus.f_ack !== 1'b0 || bus.d_ack !== 1'b0) begin
      bad++; $display("FAIL reset_acks got=%0b%0b want=00", bus.f_ack, bus.d_ack); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0b want=0", bus.mem_we); end
    total++; if (bus.mem_addr !== 16'h0000) begin bad++; $display("FAIL reset_mem_addr got=%h want=0000", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 8'h00) begin bad++; $display("FAIL reset_mem_wdata got=%h want=00", bus.mem_wdata); end
    total++; if (bus.f_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h want=0/0", bus.f_rdata, bus.d_rdata); end
    rst = 1'b1;
  endtask

  task automatic test_fetch_read();
    int   cyc;
    logic we_seen;
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 16'h0003;
    cyc = -1; we_seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.f_addr = 16'h0100;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL fetch_busy got=%0b want=1", busy); end
      end
      if (bus.mem_we === 1'b1) we_seen = 1'b1;
      if (bus.f_ack === 1'b1) begin cyc = k; break; end
    end
    bus.f_req = 1'b0;
    total++; if (cyc !== 5) begin bad++; $display("FAIL fetch_latency got=%0d want=5", cyc); end
    total++; if (bus.f_rdata !== 32'h789ABCDE) begin bad++; $display("FAIL fetch_rdata got=%h want=789abcde", bus.f_rdata); end
    total++; if (we_seen !== 1'b0) begin bad++; $display("FAIL fetch_no_we got=%0b want=0", we_seen); end
    @(negedge clk);
    total++; if (bus.f_ack !== 1'b0 || bus.f_rdata !== 32'h789ABCDE) begin
      bad++; $display("FAIL fetch_hold got ack=%0b rdata=%h want ack=0 rdata=789abcde", bus.f_ack, bus.f_rdata); end
  endtask

  task automatic test_write_read();
    int cyc;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0004; bus.d_wdata = 32'hCAFEBABE;
    @(negedge clk);
    bus.d_wdata = 32'h0;
    wait_ack(1'b1, cyc);
    bus.d_req = 1'b0;
    total++; if (cyc !== 4) begin bad++; $display("FAIL write_latency got=%0d want=4 after first beat", cyc); end
    total++; if (bus.d_rdata !== 32'h0) begin bad++; $display("FAIL write_keeps_drdata got=%h want=00000000", bus.d_rdata); end
    total++; if ({ram[4], ram[5], ram[6], ram[7]} !== 32'hCAFEBABE) begin
      bad++; $display("FAIL write_ram got=%h%h%h%h want=cafebabe", ram[4], ram[5], ram[6], ram[7]); end
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0004;
    wait_ack(1'b1, cyc);
    bus.d_req = 1'b0;
    total++; if (cyc !== 5) begin bad++; $display("FAIL read_latency got=%0d want=5", cyc); end
    total++; if (bus.d_rdata !== 32'hCAFEBABE) begin bad++; $display("FAIL read_back got=%h want=cafebabe", bus.d_rdata); end
    total++; if (bus.f_rdata !== 32'h789ABCDE) begin bad++; $display("FAIL frdata_kept got=%h want=789abcde", bus.f_rdata); end
  endtask

  task automatic test_tie(input bit expect_d_first, input bit do_reset);
    int fk, dk;
    if (do_reset) begin
      rst = 1'b0;
      @(negedge clk);
      total++; if (bus.f_rdata !== 32'h0) begin bad++; $display("FAIL tie_reset_frdata got=%h want=0", bus.f_rdata); end
    end
    @(negedge clk);
    rst = 1'b1;
    bus.f_req = 1'b1; bus.f_addr = 16'h0000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0004;
    fk = -1; dk = -1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (bus.f_ack === 1'b1 && bus.d_ack === 1'b1) begin
        total++; bad++; $display("FAIL tie_both_ack at cycle %0d got=11 want one-hot", k);
      end
      if (bus.f_ack === 1'b1 && fk < 0) begin fk = k; bus.f_req = 1'b0; end
      if (bus.d_ack === 1'b1 && dk < 0) begin dk = k; bus.d_req = 1'b0; end
      if (fk > 0 && dk > 0) break;
    end
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    total++; if (fk !== (expect_d_first ? 11 : 5)) begin
      bad++; $display("FAIL tie_f_cycle got=%0d want=%0d", fk, expect_d_first ? 11 : 5); end
    total++; if (dk !== (expect_d_first ? 5 : 11)) begin
      bad++; $display("FAIL tie_d_cycle got=%0d want=%0d", dk, expect_d_first ? 5 : 11); end
    total++; if (bus.f_rdata !== 32'h12345678) begin bad++; $display("FAIL tie_frdata got=%h want=12345678", bus.f_rdata); end
    total++; if (bus.d_rdata !== 32'hCAFEBABE) begin bad++; $display("FAIL tie_drdata got=%h want=cafebabe", bus.d_rdata); end
  endtask

  task automatic test_rr_alternate();
    int cyc;
    @(negedge clk);
    bus.f_req = 1'b1; bus.f_addr = 16'h0002;
    wait_ack(1'b0, cyc);
    bus.f_req = 1'b0;
    total++; if (bus.f_rdata !== 32'h5678CAFE) begin bad++; $display("FAIL rr_fetch got=%h want=5678cafe", bus.f_rdata); end
    test_tie(1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    int cyc;
    logic [15:0] seen [4];
    logic [15:0] want [4];
    want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000; want[3] = 16'h0001;
    @(negedge clk);
    ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'hFFFE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen[k] = bus.mem_addr;
    end
    wait_ack(1'b1, cyc);
    bus.d_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (seen[k] !== want[k]) begin bad++; $display("FAIL wrap_addr%0d got=%h want=%h", k, seen[k], want[k]); end
    end
    total++; if (cyc !== 1) begin bad++; $display("FAIL wrap_ack got=%0d want=1 after beat 3", cyc); end
    total++; if (bus.d_rdata !== 32'hAABB1234) begin bad++; $display("FAIL wrap_rdata got=%h want=aabb1234", bus.d_rdata); end
  endtask

  task automatic test_abort();
    logic ack_seen;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0000; bus.d_wdata = 32'h11223344;
    ack_seen = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (bus.d_ack === 1'b1) ack_seen = 1'b1;
    end
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL abort_mem_we got=%0b want=0", bus.mem_we); end
    total++; if (bus.d_rdata !== 32'h0) begin bad++; $display("FAIL abort_drdata got=%h want=0", bus.d_rdata); end
    rst = 1'b1; bus.d_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.d_ack === 1'b1) ack_seen = 1'b1;
    end
    total++; if (ack_seen !== 1'b0) begin bad++; $display("FAIL abort_no_ack got=%0b want=0", ack_seen); end
    total++; if ({ram[0], ram[1], ram[2], ram[3]} !== 32'h11223378) begin
      bad++; $display("FAIL abort_ram got=%h%h%h%h want=11223378", ram[0], ram[1], ram[2], ram[3]); end
  endtask

  initial begin
    logic [7:0] init_bytes [8];
    init_bytes[0] = 8'h12; init_bytes[1] = 8'h34; init_bytes[2] = 8'h56; init_bytes[3] = 8'h78;
    init_bytes[4] = 8'h9A; init_bytes[5] = 8'hBC; init_bytes[6] = 8'hDE; init_bytes[7] = 8'hF0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    for (int i = 0; i < 8; i++) ram[i] = init_bytes[i];
    rst = 1'b0;
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    test_reset();
    test_fetch_read();
    test_write_read();
    test_tie(1'b0, 1'b1);
    test_rr_alternate();
    test_wrap();
    test_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
